// File: rtl/uart_imem_loader_if.sv
// Byte stream from the UART receiver and write port towards instruction memory.
// The loader is the master: it consumes bytes and drives the memory write.
interface uart_imem_loader_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  byte_valid;
   logic [7:0]            byte_data;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (
      input  byte_valid, byte_data,
      output imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output byte_valid, byte_data,
      input  imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/uart_imem_loader.sv
// UART program loader: parses a 16-bit little-endian word count, then packs
// little-endian bytes into 32-bit words and writes them to instruction memory.
module uart_imem_loader #(
   parameter int ADDR_WIDTH     = 10,
   parameter int MAX_WORDS      = 1024,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flash,
   uart_imem_loader_if.master    io,
   output logic                  load_busy,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERROR} state_t;

   state_t        state;
   logic [1:0]    byte_idx;
   logic [7:0]    len_lo;
   logic [15:0]   len;
   logic [23:0]   asm_q;
   logic [TW-1:0] tcnt;

   logic [15:0]   n_val;
   logic          n_bad;
   logic          count_hit;

   assign n_val     = {io.byte_data, len_lo};
   assign n_bad     = (n_val == '0) || (32'(n_val) > 32'(MAX_WORDS));
   assign count_hit = (32'(word_count) == 32'(len));

   assign load_busy  = (state == LEN) || (state == DATA);
   assign load_done  = (state == DONE);
   assign load_error = (state == ERROR);

   // Load sequencer: length parse, word assembly, write strobe, timeout
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         byte_idx      <= '0;
         len_lo        <= '0;
         len           <= '0;
         asm_q         <= '0;
         tcnt          <= '0;
         word_count    <= '0;
         io.imem_we    <= 1'b0;
         io.imem_addr  <= '0;
         io.imem_wdata <= '0;
      end else begin
         io.imem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (flash) begin
                  state      <= LEN;
                  byte_idx   <= '0;
                  word_count <= '0;
                  tcnt       <= '0;
               end
            end
            LEN, DATA: begin
               if (!flash) begin
                  state    <= IDLE;
                  byte_idx <= '0;
                  tcnt     <= '0;
               end else if (state == DATA && io.imem_we && count_hit) begin
                  // word_count was bumped with the strobe, so the final write
                  // is already on the bus when completion is recognised
                  state <= DONE;
                  tcnt  <= '0;
               end else if (tcnt == T_LAST) begin
                  state <= ERROR;
                  tcnt  <= '0;
               end else if (io.byte_valid) begin
                  tcnt <= '0;
                  if (state == LEN) begin
                     if (byte_idx == 2'd0) begin
                        len_lo   <= io.byte_data;
                        byte_idx <= 2'd1;
                     end else begin
                        len      <= n_val;
                        byte_idx <= '0;
                        state    <= n_bad ? ERROR : DATA;
                     end
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                     case (byte_idx)
                        2'd0: asm_q[7:0]   <= io.byte_data;
                        2'd1: asm_q[15:8]  <= io.byte_data;
                        2'd2: asm_q[23:16] <= io.byte_data;
                        default: begin
                           io.imem_we    <= 1'b1;
                           io.imem_addr  <= word_count[ADDR_WIDTH-1:0];
                           io.imem_wdata <= {io.byte_data, asm_q};
                           word_count    <= word_count + 1'b1;
                        end
                     endcase
                  end
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            DONE, ERROR: begin
               if (!flash) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Upstream feeder for the fetch stage's instruction memory.
- Consumes the byte stream from the UART receiver (valid pulse plus byte) while the board `flash` switch is high.
- Parses a 2-byte little-endian word count, then assembles little-endian 32-bit instruction words and issues one-cycle write strobes to instruction memory.
- Drives `load_busy` so the pipeline is held while a program is being loaded; reports completion and error status.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width.
- MAX_WORDS, 1024, largest accepted word count; must be <= 2**ADDR_WIDTH.
- TIMEOUT_CYCLES, 1000000, idle cycles between bytes before a load is aborted with error.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- flash  in  1  level, load-mode enable.
- byte_valid  in  1  one-cycle pulse from UART receiver.
- byte_data  in  8  received byte, valid with byte_valid.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_WIDTH  word address of current write.
- imem_wdata  out  32  assembled instruction word.
- load_busy  out  1  high in LEN or DATA; pipeline must hold.
- load_done  out  1  high in DONE.
- load_error  out  1  high in ERROR.
- word_count  out  ADDR_WIDTH+1  words written in the current or last load.

Behaviour:
- Reset (rst=0, asynchronous, no clock edge needed):
  - state=IDLE; byte index, length, timeout counter and word_count cleared.
  - Every output is 0.
- States: IDLE, LEN, DATA, DONE, ERROR.
- IDLE:
  - byte_valid is ignored.
  - flash=1 → LEN next cycle; byte index and word_count cleared.
- LEN:
  - Collect 2 bytes: N = {byte1, byte0}.
  - On the 2nd byte, if N==0 or N>MAX_WORDS → ERROR; otherwise → DATA.
- DATA:
  - Bytes fill a 4-byte assembly register in order b0..b3.
  - On the cycle after b3's byte_valid (1-cycle latency), drive:
    - imem_we=1 for exactly one cycle;
    - imem_addr = word_count[ADDR_WIDTH-1:0];
    - imem_wdata = {b3,b2,b1,b0}.
  - word_count increments in that same cycle.
  - When the incremented count equals N → DONE next cycle.
  - imem_addr and imem_wdata hold their last values when imem_we=0.
- DONE / ERROR:
  - Held while flash=1; byte_valid is ignored.
  - word_count is frozen.
- flash=0 in any non-IDLE state → IDLE next cycle:
  - a partially assembled word is discarded, with no write;
  - a byte arriving in the same cycle as flash falling is dropped;
  - load_done and load_error clear on entry to IDLE;
  - word_count holds until the next load starts.
- Timeout, in LEN and DATA only:
  - The counter increments each cycle without byte_valid and clears on byte_valid.
  - Counter reaching TIMEOUT_CYCLES-1 → ERROR next cycle.
  - The counter is cleared on every state entry.
- Priority per cycle: reset > flash=0 > timeout > byte processing.
- A pending imem_we is still issued in the cycle a timeout is detected.
- A byte_valid while imem_we is high is accepted as b0 of the next word.
- byte_valid pulses are at most one per cycle; no back-pressure to the UART.
- Re-raising flash after DONE or ERROR requires flash=0 for ≥1 cycle (pass through IDLE).

Test Plan:
- flash=1; bytes 02 00, 13 00 00 00, 93 00 10 00 → imem_we pulses at addr 0 with data 0x00000013, then addr 1 with 0x00100093; load_done=1; word_count=2; load_busy=0 afterwards.
- flash=1; bytes 00 00 → load_error=1, no imem_we. Repeat with N=MAX_WORDS+1 → load_error=1.
- TIMEOUT_CYCLES=100; bytes 01 00 AA BB then silence → load_error=1 exactly 100 cycles after the last byte, no imem_we.
- Drop flash after 3 data bytes → IDLE, no write, load_busy=0. Re-raise flash and send 01 00 EF BE AD DE → write at addr 0, data 0xDEADBEEF.
- rst=0 asynchronously mid-DATA, between clock edges → all outputs 0 immediately. After release, bytes are ignored until flash is seen high.
- After DONE, send 4 more bytes with flash held high → no imem_we; word_count unchanged.
